// File: rtl/pipe_stage_hs.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer, a registered in_ready,
// flush in drop or bubble mode, and saturating stall/flush counters.
module pipe_stage_hs #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CTRL_W     = 9,
  parameter int unsigned FLUSH_MODE = 1,
  parameter logic [31:0] NOP_INSTR  = 32'h0800_0000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_instr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Encodings equal the entry count so occupancy is a direct read of the state.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic [DATA_W-1:0]   r_main_data,  r_skid_data;
  logic [CTRL_W-1:0]   r_main_ctrl,  r_skid_ctrl;
  logic [31:0]         r_main_instr, r_skid_instr;
  logic [CNT_W-1:0]    r_stall_cnt,  r_flush_cnt;

  state_t              w_next_state;
  logic                w_in_fire, w_out_fire;
  logic [DATA_W-1:0]   w_main_data,  w_skid_data;
  logic [CTRL_W-1:0]   w_main_ctrl,  w_skid_ctrl;
  logic [31:0]         w_main_instr, w_skid_instr;
  logic [1:0]          w_squashed;
  logic [CNT_W:0]      w_flush_sum;

  assign out_valid  = (r_state != S_EMPTY);
  assign in_ready   = r_in_ready;
  assign out_data   = r_main_data;
  assign out_ctrl   = out_valid ? r_main_ctrl : '0;
  assign out_instr  = r_main_instr;
  assign occupancy  = r_state;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;
  // Held entries that do not leave this cycle, plus the beat being accepted.
  assign w_squashed = r_state - {1'b0, w_out_fire} + {1'b0, w_in_fire};
  assign w_flush_sum = {1'b0, r_flush_cnt} + {{(CNT_W-1){1'b0}}, w_squashed};

  always_comb begin
    w_next_state = r_state;
    w_main_data  = r_main_data;
    w_main_ctrl  = r_main_ctrl;
    w_main_instr = r_main_instr;
    w_skid_data  = r_skid_data;
    w_skid_ctrl  = r_skid_ctrl;
    w_skid_instr = r_skid_instr;

    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_next_state = S_ONE;
          w_main_data  = in_data;
          w_main_ctrl  = in_ctrl;
          w_main_instr = in_instr;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_data  = in_data;
          w_main_ctrl  = in_ctrl;
          w_main_instr = in_instr;
        end else if (w_in_fire) begin
          w_next_state = S_TWO;
          w_skid_data  = in_data;
          w_skid_ctrl  = in_ctrl;
          w_skid_instr = in_instr;
        end else if (w_out_fire) begin
          w_next_state = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_out_fire) begin
          w_next_state = S_ONE;
          w_main_data  = r_skid_data;
          w_main_ctrl  = r_skid_ctrl;
          w_main_instr = r_skid_instr;
        end
      end
      default: w_next_state = S_EMPTY;
    endcase

    if (flush) begin
      if (FLUSH_MODE == 0) begin
        // Drop: nothing is loaded, so out_data/out_instr keep their last value.
        w_next_state = S_EMPTY;
        w_main_data  = r_main_data;
        w_main_ctrl  = r_main_ctrl;
        w_main_instr = r_main_instr;
        w_skid_data  = r_skid_data;
        w_skid_ctrl  = r_skid_ctrl;
        w_skid_instr = r_skid_instr;
      end else begin
        if (w_next_state != S_EMPTY) begin
          w_main_ctrl  = '0;
          w_main_instr = NOP_INSTR;
        end
        if (w_next_state == S_TWO) begin
          w_skid_ctrl  = '0;
          w_skid_instr = NOP_INSTR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_in_ready   <= 1'b1;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
      r_main_instr <= NOP_INSTR;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_skid_instr <= NOP_INSTR;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_in_ready   <= (w_next_state != S_TWO);
      r_main_data  <= w_main_data;
      r_main_ctrl  <= w_main_ctrl;
      r_main_instr <= w_main_instr;
      r_skid_data  <= w_skid_data;
      r_skid_ctrl  <= w_skid_ctrl;
      r_skid_instr <= w_skid_instr;
      if (out_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush)
        r_flush_cnt <= w_flush_sum[CNT_W] ? '1 : w_flush_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: a drop-mode instance (4-bit counters) and a bubble-mode
// instance (16-bit counters) share the same stimulus.
module tb_pipe_stage_hs;

  localparam logic [31:0] NOP = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [8:0]  in_ctrl;
  logic [31:0] in_instr;

  logic        d_in_ready, d_out_valid, b_in_ready, b_out_valid;
  logic [63:0] d_out_data, b_out_data;
  logic [8:0]  d_out_ctrl, b_out_ctrl;
  logic [31:0] d_out_instr, b_out_instr;
  logic [1:0]  d_occ, b_occ;
  logic [3:0]  d_stall, d_flush;
  logic [15:0] b_stall, b_flush;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(64), .CTRL_W(9), .FLUSH_MODE(0), .NOP_INSTR(NOP), .CNT_W(4)) u_drop (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_instr(in_instr), .out_valid(d_out_valid),
    .out_ready(out_ready), .out_data(d_out_data), .out_ctrl(d_out_ctrl), .out_instr(d_out_instr),
    .occupancy(d_occ), .stall_cnt(d_stall), .flush_cnt(d_flush));

  pipe_stage_hs #(.DATA_W(64), .CTRL_W(9), .FLUSH_MODE(1), .NOP_INSTR(NOP), .CNT_W(16)) u_bub (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_instr(in_instr), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl), .out_instr(b_out_instr),
    .occupancy(b_occ), .stall_cnt(b_stall), .flush_cnt(b_flush));

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic [8:0]  ic;
    logic        ordy;
    logic        ev;
    logic [63:0] ed;
    logic [8:0]  ec;
    logic [1:0]  eocc;
    logic        eir;
    logic [15:0] estall;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic iv, logic [63:0] id, logic [8:0] ic, logic ordy, logic ev,
                              logic [63:0] ed, logic [8:0] ec, logic [1:0] eocc, logic eir,
                              logic [15:0] estall);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.ev = ev; v.ed = ed; v.ec = ec;
    v.eocc = eocc; v.eir = eir; v.estall = estall;
    return v;
  endfunction

  function automatic logic [31:0] instr_of(logic [63:0] d);
    return {8'hA5, d[23:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [63:0] id, input logic [8:0] ic, input logic ordy);
    in_valid = iv; in_data = id; in_ctrl = ic; in_instr = instr_of(id); out_ready = ordy;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 64'h99, 9'h1FF, 1'b0);
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, 64'h0, 9'h0, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_d_valid"}, 64'(d_out_valid), 64'd0);
    chk({tag, "_d_occ"},   64'(d_occ),       64'd0);
    chk({tag, "_d_rdy"},   64'(d_in_ready),  64'd1);
    chk({tag, "_d_data"},  d_out_data,       64'd0);
    chk({tag, "_d_ctrl"},  64'(d_out_ctrl),  64'd0);
    chk({tag, "_d_instr"}, 64'(d_out_instr), 64'(NOP));
    chk({tag, "_d_stall"}, 64'(d_stall),     64'd0);
    chk({tag, "_d_flush"}, 64'(d_flush),     64'd0);
    chk({tag, "_b_valid"}, 64'(b_out_valid), 64'd0);
    chk({tag, "_b_occ"},   64'(b_occ),       64'd0);
    chk({tag, "_b_instr"}, 64'(b_out_instr), 64'(NOP));
    chk({tag, "_b_stall"}, 64'(b_stall),     64'd0);
  endtask

  initial begin
    // Stream 1..8, drain, then backpressure A/B with an ignored offer while full.
    for (int unsigned k = 1; k <= 8; k++)
      tbl[k-1] = mk(1'b1, 64'(k), 9'(k), 1'b1, 1'b1, 64'(k), 9'(k), 2'd1, 1'b1, 16'd0);
    tbl[8]  = mk(1'b0, 64'h0,    9'h0,   1'b1, 1'b0, 64'h8,    9'h0,   2'd0, 1'b1, 16'd0);
    tbl[9]  = mk(1'b1, 64'hA0A0, 9'h0AA, 1'b0, 1'b1, 64'hA0A0, 9'h0AA, 2'd1, 1'b1, 16'd0);
    tbl[10] = mk(1'b0, 64'h0,    9'h0,   1'b0, 1'b1, 64'hA0A0, 9'h0AA, 2'd1, 1'b1, 16'd1);
    tbl[11] = mk(1'b0, 64'h0,    9'h0,   1'b0, 1'b1, 64'hA0A0, 9'h0AA, 2'd1, 1'b1, 16'd2);
    tbl[12] = mk(1'b1, 64'hB0B0, 9'h0BB, 1'b0, 1'b1, 64'hA0A0, 9'h0AA, 2'd2, 1'b0, 16'd3);
    tbl[13] = mk(1'b1, 64'hC0C0, 9'h0CC, 1'b0, 1'b1, 64'hA0A0, 9'h0AA, 2'd2, 1'b0, 16'd4);
    tbl[14] = mk(1'b0, 64'h0,    9'h0,   1'b1, 1'b1, 64'hB0B0, 9'h0BB, 2'd1, 1'b1, 16'd4);
    tbl[15] = mk(1'b0, 64'h0,    9'h0,   1'b1, 1'b0, 64'hB0B0, 9'h0,   2'd0, 1'b1, 16'd4);
    tbl[16] = mk(1'b0, 64'h0,    9'h0,   1'b1, 1'b0, 64'hB0B0, 9'h0,   2'd0, 1'b1, 16'd4);

    do_reset();
    chk_reset("reset");

    for (int unsigned i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].ic, tbl[i].ordy);
      tick();
      chk($sformatf("v%0d_d_valid", i), 64'(d_out_valid), 64'(tbl[i].ev));
      chk($sformatf("v%0d_d_data", i),  d_out_data,       tbl[i].ed);
      chk($sformatf("v%0d_d_ctrl", i),  64'(d_out_ctrl),  64'(tbl[i].ec));
      chk($sformatf("v%0d_d_instr", i), 64'(d_out_instr), 64'(instr_of(tbl[i].ed)));
      chk($sformatf("v%0d_d_occ", i),   64'(d_occ),       64'(tbl[i].eocc));
      chk($sformatf("v%0d_d_rdy", i),   64'(d_in_ready),  64'(tbl[i].eir));
      chk($sformatf("v%0d_d_stall", i), 64'(d_stall),     64'(tbl[i].estall[3:0]));
      chk($sformatf("v%0d_b_valid", i), 64'(b_out_valid), 64'(tbl[i].ev));
      chk($sformatf("v%0d_b_data", i),  b_out_data,       tbl[i].ed);
      chk($sformatf("v%0d_b_ctrl", i),  64'(b_out_ctrl),  64'(tbl[i].ec));
      chk($sformatf("v%0d_b_stall", i), 64'(b_stall),     64'(tbl[i].estall));
      chk($sformatf("v%0d_b_flush", i), 64'(b_flush),     64'd0);
    end

    // Flush with two held entries.
    do_reset();
    drive(1'b1, 64'h1111, 9'h1FF, 1'b0); tick();
    drive(1'b1, 64'h2222, 9'h1FF, 1'b0); tick();
    chk("fl2_pre_occ", 64'(b_occ), 64'd2);
    drive(1'b0, 64'h0, 9'h0, 1'b0); flush = 1'b1; tick(); flush = 1'b0;
    chk("fl2_d_valid", 64'(d_out_valid), 64'd0);
    chk("fl2_d_occ",   64'(d_occ),       64'd0);
    chk("fl2_d_rdy",   64'(d_in_ready),  64'd1);
    chk("fl2_d_flush", 64'(d_flush),     64'd2);
    chk("fl2_d_data",  d_out_data,       64'h1111);
    chk("fl2_b_valid", 64'(b_out_valid), 64'd1);
    chk("fl2_b_occ",   64'(b_occ),       64'd2);
    chk("fl2_b_rdy",   64'(b_in_ready),  64'd0);
    chk("fl2_b_ctrl",  64'(b_out_ctrl),  64'd0);
    chk("fl2_b_instr", 64'(b_out_instr), 64'(NOP));
    chk("fl2_b_data",  b_out_data,       64'h1111);
    chk("fl2_b_flush", 64'(b_flush),     64'd2);
    drive(1'b0, 64'h0, 9'h0, 1'b1); tick();
    chk("fl2_b_second_valid", 64'(b_out_valid), 64'd1);
    chk("fl2_b_second_data",  b_out_data,       64'h2222);
    chk("fl2_b_second_ctrl",  64'(b_out_ctrl),  64'd0);
    chk("fl2_b_second_instr", 64'(b_out_instr), 64'(NOP));
    chk("fl2_d_stays_empty",  64'(d_out_valid), 64'd0);
    tick();
    chk("fl2_b_drained", 64'(b_occ), 64'd0);

    // Flush in ONE with a simultaneous accept and consume.
    do_reset();
    drive(1'b1, 64'h3333, 9'h1FF, 1'b0); tick();
    drive(1'b1, 64'h4444, 9'h1FF, 1'b1); flush = 1'b1; tick(); flush = 1'b0;
    chk("fl1_d_occ",   64'(d_occ),       64'd0);
    chk("fl1_d_flush", 64'(d_flush),     64'd1);
    chk("fl1_b_occ",   64'(b_occ),       64'd1);
    chk("fl1_b_data",  b_out_data,       64'h4444);
    chk("fl1_b_ctrl",  64'(b_out_ctrl),  64'd0);
    chk("fl1_b_instr", 64'(b_out_instr), 64'(NOP));
    chk("fl1_b_flush", 64'(b_flush),     64'd1);
    drive(1'b0, 64'h0, 9'h0, 1'b1); tick();

    // Stall counter saturation on the 4-bit instance.
    do_reset();
    drive(1'b1, 64'h5A5A, 9'h001, 1'b0); tick();
    drive(1'b0, 64'h0, 9'h0, 1'b0);
    repeat (20) tick();
    chk("sat_d_stall", 64'(d_stall),     64'hF);
    chk("sat_b_stall", 64'(b_stall),     64'd20);
    chk("sat_d_valid", 64'(d_out_valid), 64'd1);

    // Reset while full, then a single beat.
    do_reset();
    drive(1'b1, 64'h6666, 9'h1FF, 1'b0); tick();
    drive(1'b1, 64'h7777, 9'h1FF, 1'b0); tick();
    chk("rfull_pre_occ", 64'(d_occ), 64'd2);
    do_reset();
    chk_reset("rfull");
    drive(1'b1, 64'h55, 9'h015, 1'b1); tick();
    chk("post_rst_valid", 64'(d_out_valid), 64'd1);
    chk("post_rst_data",  d_out_data,       64'h55);
    chk("post_rst_ctrl",  64'(b_out_ctrl),  64'h015);
    drive(1'b0, 64'h0, 9'h0, 1'b1); tick();
    chk("post_rst_empty", 64'(d_occ),       64'd0);
    chk("post_rst_hold",  d_out_data,       64'h55);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
